// File: rtl/illm_seq_pkg.sv
// Shared definitions for the illm_d1 lane sequencer.
// Purpose : default widths for the sequencer and the state encodings of the
//           scatter and gather state machines.
// Contents: DEF_LANES, DEF_IW, DEF_OW, sc_state_t, ga_state_t.
package illm_seq_pkg;

  localparam int DEF_LANES = 8;
  localparam int DEF_IW    = 16;
  localparam int DEF_OW    = 9;

  // Scatter side: collect a row, issue it to the lanes, or issue an all-lane EOS.
  typedef enum logic [1:0] {
    SC_FILL,
    SC_ISSUE,
    SC_EOS
  } sc_state_t;

  // Gather side: collect the lane results, then serialise them.
  typedef enum logic {
    GA_COLLECT,
    GA_DRAIN
  } ga_state_t;

endpackage

// File: rtl/illm_lane_sequencer_gather.sv
// illm_row_gather
// Purpose : collects one result per lane from the butterfly stage, then
//           serialises the row lane 0..7 onto a single stream. Rows that
//           carry any EOS flag collapse into one EOS token. A 3-bit row
//           counter marks the end of each 8x8 block with blk_done.
// Ports   : clock, reset (sync, active-high)
//           lb_d/lb_e/lb_v in, lb_b out : per-lane result streams
//           o_d/o_e/o_v out, o_b in     : serial output stream
//           blk_done out                : pulse after the 8th data row drains
//           err_eos_mix out             : sticky, EOS row had mixed e flags
module illm_row_gather
  import illm_seq_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int OW    = DEF_OW
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [LANES*OW-1:0] lb_d,
  input  logic [LANES-1:0]    lb_e,
  input  logic [LANES-1:0]    lb_v,
  output logic [LANES-1:0]    lb_b,
  output logic [OW-1:0]       o_d,
  output logic                o_e,
  output logic                o_v,
  input  logic                o_b,
  output logic                blk_done,
  output logic                err_eos_mix
);

  localparam int IDXW = $clog2(LANES);

  ga_state_t             state_q, state_n;
  logic [LANES*OW-1:0]   row_q, row_n;
  logic [LANES-1:0]      e_q, e_n;
  logic                  eos_row_q, eos_row_n;
  logic [IDXW-1:0]       widx_q, widx_n;
  logic [2:0]            rows_q, rows_n;
  logic [LANES-1:0]      lb_b_n;
  logic [OW-1:0]         o_d_n;
  logic                  o_e_n, o_v_n;
  logic                  blk_done_n, err_eos_mix_n;
  logic [LANES-1:0]      cap;
  logic [LANES-1:0]      mask_n;

  // lb_b doubles as the capture mask: a lane is blocked once its word is held.
  assign cap    = lb_v & ~lb_b;
  assign mask_n = lb_b | cap;

  // Next-state and registered-output logic for the gather FSM.
  always_comb begin
    state_n       = state_q;
    row_n         = row_q;
    e_n           = e_q;
    eos_row_n     = eos_row_q;
    widx_n        = widx_q;
    rows_n        = rows_q;
    lb_b_n        = lb_b;
    o_d_n         = o_d;
    o_e_n         = o_e;
    o_v_n         = o_v;
    blk_done_n    = 1'b0;
    err_eos_mix_n = err_eos_mix;

    case (state_q)
      GA_COLLECT: begin
        for (int i = 0; i < LANES; i++) begin
          if (cap[i]) begin
            row_n[i*OW +: OW] = lb_d[i*OW +: OW];
            e_n[i]            = lb_e[i];
          end
        end
        lb_b_n = mask_n;
        // The last lane may be captured in this very cycle, so test the
        // updated mask rather than the registered one.
        if (&mask_n) begin
          state_n = GA_DRAIN;
          widx_n  = '0;
          o_v_n   = 1'b1;
          if (|e_n) begin
            eos_row_n = 1'b1;
            o_e_n     = 1'b1;
            o_d_n     = '0;
            if (e_n != '1) err_eos_mix_n = 1'b1;
          end else begin
            eos_row_n = 1'b0;
            o_e_n     = 1'b0;
            o_d_n     = row_n[OW-1:0];
          end
        end
      end

      GA_DRAIN: begin
        if (o_v && !o_b) begin
          if (eos_row_q || widx_q == IDXW'(LANES-1)) begin
            state_n = GA_COLLECT;
            o_v_n   = 1'b0;
            o_e_n   = 1'b0;
            lb_b_n  = '0;
            e_n     = '0;
            if (eos_row_q) begin
              rows_n = 3'd0;
            end else begin
              rows_n = rows_q + 3'd1;
              if (rows_q == 3'd7) blk_done_n = 1'b1;
            end
          end else begin
            widx_n = widx_q + 1'b1;
            o_d_n  = row_q[(int'(widx_q) + 1)*OW +: OW];
          end
        end
      end

      default: state_n = GA_COLLECT;
    endcase
  end

  // State and output registers; reset discards any partially gathered row.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= GA_COLLECT;
      row_q       <= '0;
      e_q         <= '0;
      eos_row_q   <= 1'b0;
      widx_q      <= '0;
      rows_q      <= 3'd0;
      lb_b        <= '0;
      o_d         <= '0;
      o_e         <= 1'b0;
      o_v         <= 1'b0;
      blk_done    <= 1'b0;
      err_eos_mix <= 1'b0;
    end else begin
      state_q     <= state_n;
      row_q       <= row_n;
      e_q         <= e_n;
      eos_row_q   <= eos_row_n;
      widx_q      <= widx_n;
      rows_q      <= rows_n;
      lb_b        <= lb_b_n;
      o_d         <= o_d_n;
      o_e         <= o_e_n;
      o_v         <= o_v_n;
      blk_done    <= blk_done_n;
      err_eos_mix <= err_eos_mix_n;
    end
  end

endmodule

// File: rtl/illm_lane_sequencer.sv
// illm_lane_sequencer
// Purpose : feeds and drains the 8-lane IDCT 1-D butterfly stage. The scatter
//           side gathers 8 serial coefficients into a row and issues it to all
//           lanes at once; the gather side (illm_row_gather) serialises lane
//           results back onto one stream.
// Ports   : clock, reset (sync, active-high)
//           s_d/s_e/s_v in, s_b out     : serial coefficient input
//           la_d/la_e/la_v out, la_b in : per-lane streams into the stage
//           lb_d/lb_e/lb_v in, lb_b out : per-lane results from the stage
//           o_d/o_e/o_v out, o_b in     : serial result output
//           blk_done, err_partial, err_eos_mix : status outputs
module illm_lane_sequencer
  import illm_seq_pkg::*;
#(
  parameter int IW    = DEF_IW,
  parameter int OW    = DEF_OW,
  parameter int LANES = DEF_LANES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IW-1:0]       s_d,
  input  logic                s_e,
  input  logic                s_v,
  output logic                s_b,
  output logic [LANES*IW-1:0] la_d,
  output logic [LANES-1:0]    la_e,
  output logic [LANES-1:0]    la_v,
  input  logic [LANES-1:0]    la_b,
  input  logic [LANES*OW-1:0] lb_d,
  input  logic [LANES-1:0]    lb_e,
  input  logic [LANES-1:0]    lb_v,
  output logic [LANES-1:0]    lb_b,
  output logic [OW-1:0]       o_d,
  output logic                o_e,
  output logic                o_v,
  input  logic                o_b,
  output logic                blk_done,
  output logic                err_partial,
  output logic                err_eos_mix
);

  localparam int IDXW = $clog2(LANES);

  sc_state_t             state_q, state_n;
  logic [IDXW-1:0]       idx_q, idx_n;
  logic [LANES*IW-1:0]   row_q, row_n;
  logic                  eos_pend_q, eos_pend_n;
  logic                  s_b_n;
  logic [LANES*IW-1:0]   la_d_n;
  logic [LANES-1:0]      la_e_n, la_v_n;
  logic                  err_partial_n;
  logic                  s_xfer;
  logic [LANES-1:0]      lane_xfer;

  assign s_xfer    = s_v & ~s_b;
  assign lane_xfer = la_v & ~la_b;

  // Scatter FSM. la_v itself is the inverse of the per-lane done mask: each
  // lane drops its valid on its own transfer, and the row is retired once
  // every lane has dropped. A mid-row EOS pads the row with zeros, issues it,
  // and remembers the EOS so it follows as an all-lane EOS issue.
  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    row_n         = row_q;
    eos_pend_n    = eos_pend_q;
    s_b_n         = s_b;
    la_d_n        = la_d;
    la_v_n        = la_v & ~lane_xfer;
    la_e_n        = la_e & ~lane_xfer;
    err_partial_n = err_partial;

    case (state_q)
      SC_FILL: begin
        s_b_n = 1'b0;
        if (s_xfer) begin
          if (!s_e) begin
            row_n[idx_q*IW +: IW] = s_d;
            if (idx_q == IDXW'(LANES-1)) begin
              state_n = SC_ISSUE;
              s_b_n   = 1'b1;
              la_v_n  = '1;
              la_e_n  = '0;
              la_d_n  = row_n;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end else if (idx_q == '0) begin
            state_n = SC_EOS;
            s_b_n   = 1'b1;
            la_v_n  = '1;
            la_e_n  = '1;
            la_d_n  = '0;
          end else begin
            err_partial_n = 1'b1;
            eos_pend_n    = 1'b1;
            for (int i = 0; i < LANES; i++) begin
              if (i >= int'(idx_q)) row_n[i*IW +: IW] = '0;
            end
            state_n = SC_ISSUE;
            s_b_n   = 1'b1;
            la_v_n  = '1;
            la_e_n  = '0;
            la_d_n  = row_n;
          end
        end
      end

      SC_ISSUE: begin
        if (la_v_n == '0) begin
          idx_n = '0;
          if (eos_pend_q) begin
            state_n    = SC_EOS;
            eos_pend_n = 1'b0;
            la_v_n     = '1;
            la_e_n     = '1;
            la_d_n     = '0;
          end else begin
            state_n = SC_FILL;
            s_b_n   = 1'b0;
          end
        end
      end

      SC_EOS: begin
        if (la_v_n == '0) begin
          idx_n   = '0;
          state_n = SC_FILL;
          s_b_n   = 1'b0;
        end
      end

      default: state_n = SC_FILL;
    endcase
  end

  // Scatter state and output registers; reset drops any buffered tokens.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SC_FILL;
      idx_q       <= '0;
      row_q       <= '0;
      eos_pend_q  <= 1'b0;
      s_b         <= 1'b0;
      la_d        <= '0;
      la_e        <= '0;
      la_v        <= '0;
      err_partial <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      row_q       <= row_n;
      eos_pend_q  <= eos_pend_n;
      s_b         <= s_b_n;
      la_d        <= la_d_n;
      la_e        <= la_e_n;
      la_v        <= la_v_n;
      err_partial <= err_partial_n;
    end
  end

  illm_row_gather #(
    .LANES (LANES),
    .OW    (OW)
  ) u_gather (
    .clock       (clock),
    .reset       (reset),
    .lb_d        (lb_d),
    .lb_e        (lb_e),
    .lb_v        (lb_v),
    .lb_b        (lb_b),
    .o_d         (o_d),
    .o_e         (o_e),
    .o_v         (o_v),
    .o_b         (o_b),
    .blk_done    (blk_done),
    .err_eos_mix (err_eos_mix)
  );

endmodule

// File: tb/tb_illm_lane_sequencer.sv
// Directed testbench for illm_lane_sequencer: scatter issue, staggered lanes,
// partial and plain EOS, out-of-order gather with output stalls, block
// boundary pulse, EOS rows and reset in the middle of a drain.
module tb_illm_lane_sequencer;

  localparam int L  = 8;
  localparam int IW = 16;
  localparam int OW = 9;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [IW-1:0]   s_d   = '0;
  logic            s_e   = 1'b0;
  logic            s_v   = 1'b0;
  logic            s_b;
  logic [L*IW-1:0] la_d;
  logic [L-1:0]    la_e;
  logic [L-1:0]    la_v;
  logic [L-1:0]    la_b  = '0;
  logic [L*OW-1:0] lb_d  = '0;
  logic [L-1:0]    lb_e  = '0;
  logic [L-1:0]    lb_v  = '0;
  logic [L-1:0]    lb_b;
  logic [OW-1:0]   o_d;
  logic            o_e;
  logic            o_v;
  logic            o_b   = 1'b0;
  logic            blk_done;
  logic            err_partial;
  logic            err_eos_mix;

  int tests_run    = 0;
  int tests_failed = 0;
  int words_total  = 0;
  int pulses       = 0;
  int pulse_at     = -1;
  logic [OW-1:0] got_d[$];
  logic          got_e[$];

  illm_lane_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .s_d         (s_d),
    .s_e         (s_e),
    .s_v         (s_v),
    .s_b         (s_b),
    .la_d        (la_d),
    .la_e        (la_e),
    .la_v        (la_v),
    .la_b        (la_b),
    .lb_d        (lb_d),
    .lb_e        (lb_e),
    .lb_v        (lb_v),
    .lb_b        (lb_b),
    .o_d         (o_d),
    .o_e         (o_e),
    .o_v         (o_v),
    .o_b         (o_b),
    .blk_done    (blk_done),
    .err_partial (err_partial),
    .err_eos_mix (err_eos_mix)
  );

  always #5 clock = ~clock;

  // Advance to the next falling edge and note any blk_done pulse together with
  // the number of data words drained so far.
  task automatic tick();
    @(negedge clock);
    if (blk_done === 1'b1) begin
      pulses++;
      pulse_at = words_total;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Push one serial token, waiting (bounded) for s_b to drop first.
  task automatic applyStimulus(input logic [IW-1:0] d, input logic e);
    int n;
    n = 0;
    while (s_b !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkOutput("s_b_timeout", s_b, 0);
    s_v = 1'b1;
    s_d = d;
    s_e = e;
    tick();
    s_v = 1'b0;
    s_e = 1'b0;
  endtask

  task automatic loadLbData(input logic [OW-1:0] base);
    for (int i = 0; i < L; i++) lb_d[i*OW +: OW] = base + OW'(i);
  endtask

  // Collect n output tokens, optionally toggling o_b every cycle.
  task automatic drainWords(input int n, input bit toggle);
    int cyc;
    cyc = 0;
    got_d.delete();
    got_e.delete();
    while (got_d.size() < n && cyc < 200) begin
      o_b = toggle ? ~o_b : 1'b0;
      if (o_v === 1'b1 && o_b === 1'b0) begin
        got_d.push_back(o_d);
        got_e.push_back(o_e);
        if (o_e === 1'b0) words_total++;
      end
      tick();
      cyc++;
    end
    o_b = 1'b0;
    if (cyc >= 200) checkOutput("drain_timeout", got_d.size(), n);
  endtask

  // Present a data row to the gather side (all lanes at once, or one lane per
  // cycle in a scrambled order) and check the serial result.
  task automatic dataRow(input logic [OW-1:0] base, input bit ordered, input bit toggle);
    int order[8];
    order = '{7, 0, 5, 2, 6, 1, 4, 3};
    loadLbData(base);
    lb_e = '0;
    if (ordered) begin
      for (int k = 0; k < L; k++) begin
        lb_v = L'(1) << order[k];
        tick();
        if (k == 0) checkOutput("ga_first_mask", lb_b, 8'h80);
      end
    end else begin
      lb_v = '1;
      tick();
    end
    lb_v = '0;
    drainWords(8, toggle);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      checkOutput("ga_word", got_d[i], base + OW'(i));
      checkOutput("ga_word_e", got_e[i], 0);
    end
    checkOutput("ga_idle_after", o_v, 0);
  endtask

  task automatic eosRow(input logic [L-1:0] eflags);
    loadLbData(9'h0AA);
    lb_e = eflags;
    lb_v = '1;
    tick();
    lb_v = '0;
    lb_e = '0;
    drainWords(1, 1'b0);
    checkOutput("eos_tok_e", got_e[0], 1);
    checkOutput("eos_tok_d", got_d[0], 0);
    checkOutput("eos_single", o_v, 0);
  endtask

  initial begin
    // Reset values
    repeat (2) tick();
    checkOutput("rst_s_b", s_b, 0);
    checkOutput("rst_la_v", la_v, 0);
    checkOutput("rst_la_e", la_e, 0);
    checkOutput("rst_la_d", la_d, 0);
    checkOutput("rst_lb_b", lb_b, 0);
    checkOutput("rst_o_v", o_v, 0);
    checkOutput("rst_o_e", o_e, 0);
    checkOutput("rst_o_d", o_d, 0);
    checkOutput("rst_blk", blk_done, 0);
    checkOutput("rst_errp", err_partial, 0);
    checkOutput("rst_errm", err_eos_mix, 0);
    reset = 1'b0;
    tick();

    // Scatter basic
    for (int i = 1; i <= 8; i++) applyStimulus(IW'(i), 1'b0);
    checkOutput("sc_la_v", la_v, 8'hFF);
    checkOutput("sc_la_e", la_e, 8'h00);
    checkOutput("sc_la_d", la_d, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    checkOutput("sc_s_b_hi", s_b, 1);
    tick();
    checkOutput("sc_la_v_clr", la_v, 8'h00);
    checkOutput("sc_s_b_lo", s_b, 0);

    // Staggered lanes: lane 3 stalled for 5 cycles
    la_b = 8'h08;
    for (int i = 0; i < 8; i++) applyStimulus(16'h0010 + IW'(i), 1'b0);
    checkOutput("st_la_v_issue", la_v, 8'hFF);
    tick();
    checkOutput("st_la_v_one", la_v, 8'h08);
    repeat (3) tick();
    checkOutput("st_la_v_held", la_v, 8'h08);
    checkOutput("st_lane3_d", la_d[3*IW +: IW], 16'h0013);
    checkOutput("st_s_b_held", s_b, 1);
    la_b = 8'h00;
    tick();
    checkOutput("st_la_v_done", la_v, 8'h00);
    checkOutput("st_s_b_lo", s_b, 0);

    // Partial row then EOS
    applyStimulus(16'h00A1, 1'b0);
    applyStimulus(16'h00A2, 1'b0);
    applyStimulus(16'h00A3, 1'b0);
    checkOutput("pe_errp_pre", err_partial, 0);
    applyStimulus(16'hDEAD, 1'b1);
    checkOutput("pe_errp", err_partial, 1);
    checkOutput("pe_la_v", la_v, 8'hFF);
    checkOutput("pe_la_e", la_e, 8'h00);
    checkOutput("pe_la_d", la_d, 128'h0000_0000_0000_0000_0000_00A3_00A2_00A1);
    checkOutput("pe_s_b", s_b, 1);
    tick();
    checkOutput("pe_eos_v", la_v, 8'hFF);
    checkOutput("pe_eos_e", la_e, 8'hFF);
    checkOutput("pe_eos_d", la_d, 0);
    checkOutput("pe_eos_s_b", s_b, 1);
    tick();
    checkOutput("pe_end_v", la_v, 8'h00);
    checkOutput("pe_end_s_b", s_b, 0);

    // EOS on an empty row goes straight to an all-lane EOS
    applyStimulus(16'h0000, 1'b1);
    checkOutput("eo_la_v", la_v, 8'hFF);
    checkOutput("eo_la_e", la_e, 8'hFF);
    checkOutput("eo_la_d", la_d, 0);
    tick();
    checkOutput("eo_end_v", la_v, 8'h00);
    checkOutput("eo_sticky", err_partial, 1);

    // Gather order with output stalls, then the rest of the block
    dataRow(9'h100, 1'b1, 1'b1);
    for (int r = 0; r < 6; r++) dataRow(9'h020 + OW'(r*8), 1'b0, 1'b0);
    checkOutput("blk_none_yet", pulses, 0);
    dataRow(9'h070, 1'b0, 1'b1);
    checkOutput("blk_pulse", blk_done, 1);
    checkOutput("blk_pulse_words", pulse_at, 64);
    tick();
    checkOutput("blk_single", blk_done, 0);
    checkOutput("blk_count", pulses, 1);

    // EOS rows reset the row counter
    for (int r = 0; r < 3; r++) dataRow(9'h040 + OW'(r), 1'b0, 1'b0);
    eosRow(8'hFF);
    checkOutput("eos_mix_clean", err_eos_mix, 0);
    eosRow(8'h0F);
    checkOutput("eos_mix_set", err_eos_mix, 1);
    for (int r = 0; r < 5; r++) dataRow(9'h080 + OW'(r), 1'b0, 1'b0);
    checkOutput("eos_cnt_reset", pulses, 1);
    for (int r = 0; r < 3; r++) dataRow(9'h0C0 + OW'(r), 1'b0, 1'b0);
    checkOutput("blk2_pulse", blk_done, 1);
    checkOutput("blk2_count", pulses, 2);

    // Reset in the middle of a drain, with scatter tokens buffered
    applyStimulus(16'h0BAD, 1'b0);
    applyStimulus(16'h0BEE, 1'b0);
    loadLbData(9'h050);
    lb_v = '1;
    tick();
    lb_v = '0;
    drainWords(4, 1'b0);
    checkOutput("md_word3", got_d[3], 9'h053);
    checkOutput("md_o_v_pre", o_v, 1);
    reset = 1'b1;
    tick();
    checkOutput("md_o_v", o_v, 0);
    checkOutput("md_lb_b", lb_b, 0);
    checkOutput("md_s_b", s_b, 0);
    checkOutput("md_la_v", la_v, 0);
    checkOutput("md_errp", err_partial, 0);
    checkOutput("md_errm", err_eos_mix, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) applyStimulus(16'h0021 + IW'(i), 1'b0);
    checkOutput("md_sc_la_d", la_d, 128'h0028_0027_0026_0025_0024_0023_0022_0021);
    tick();
    dataRow(9'h060, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/illm_lane_sequencer.md
Name: illm_lane_sequencer

Overview:
Sequencer that feeds and drains the 8-lane IDCT 1-D butterfly stage (illm_d1 page: 8 × 16-bit input streams a0..a7, 8 × 9-bit output streams b0..b7).
- Scatter side: collects 8 consecutive tokens of one serial 16-bit coefficient stream into a row, then issues the row to all 8 lanes in parallel.
- Gather side: collects the 8 lane results, then serialises them lane 0..7 onto one 9-bit stream.
- Handles end-of-stream tokens, partial rows and per-lane back-pressure. Counts rows to mark 8×8 block boundaries.

Parameters:
- IW, 16, input token width (s_d, lane a data).
- OW, 9, output token width (lane b data, o_d).
- LANES, 8, lanes per row; fixed at 8 for this stage; counter widths derive from it.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- s_d  in  IW  serial input data.
- s_e  in  1  serial input end-of-stream flag.
- s_v  in  1  serial input valid.
- s_b  out  1  serial input back-pressure.
- la_d  out  LANES*IW  lane-i data at [i*IW +: IW].
- la_e  out  LANES  per-lane end-of-stream.
- la_v  out  LANES  per-lane valid.
- la_b  in  LANES  per-lane back-pressure from the stage.
- lb_d  in  LANES*OW  stage result data, lane i at [i*OW +: OW].
- lb_e  in  LANES  stage result end-of-stream.
- lb_v  in  LANES  stage result valid.
- lb_b  out  LANES  back-pressure to the stage.
- o_d  out  OW  serial output data.
- o_e  out  1  serial output end-of-stream.
- o_v  out  1  serial output valid.
- o_b  in  1  serial output back-pressure.
- blk_done  out  1  one-cycle pulse when the 8th data row of a block finishes draining.
- err_partial  out  1  sticky: EOS arrived mid-row.
- err_eos_mix  out  1  sticky: gathered row had mixed e flags.

Behaviour:
- Transfer rule: a token moves on a stream in any cycle with v=1 and b=0.
  - Producers hold d/e/v stable while b=1. All la_*, o_* and s_b/lb_b are registered.
- Reset (synchronous) values:
  - s_b=0, la_v=0, la_e=0, la_d=0.
  - lb_b=0, o_v=0, o_e=0, o_d=0.
  - blk_done=0, err_* =0.
  - Both FSMs enter their collect state; all counters and masks are cleared.
  - Reset mid-row discards buffered tokens. No partial output is emitted.
- Scatter FSM:
  - SC_FILL: s_b=0. Each data transfer (s_e=0) writes s_d to row[idx] and increments idx. When idx=7 is written, go to SC_ISSUE.
  - SC_ISSUE: s_b=1 and la_v=8'hFF the cycle after the 8th accept (latency 1). Lane i clears la_v[i] on its own transfer (done mask). When all 8 lanes are done, idx=0 and the FSM returns to SC_FILL on the next cycle.
  - EOS with idx=0: go to SC_EOS. la_v=la_e=8'hFF and la_d=0. Lanes retire individually as in SC_ISSUE, then return to SC_FILL.
  - EOS with idx≠0: set err_partial. Pad row[idx..7] with 0, issue the row (SC_ISSUE), then SC_EOS. The EOS token stays pending: s_b=1 until it is issued.
- Gather FSM:
  - GA_COLLECT: lb_b[i]=0 until lane i is captured, then 1. Capture lb_d[i] and lb_e[i] into the gather row. When all 8 are captured, go to GA_DRAIN.
    - Captures may arrive in any order and in different cycles.
    - A simultaneous capture of the last lane is counted in that cycle.
  - GA_DRAIN, data row: emit row[0..7] serially, o_e=0. Each word advances only on o_v=1 and o_b=0. After word 7 is taken, return to GA_COLLECT with all lb_b=0.
  - GA_DRAIN, EOS row (any lb_e set): emit exactly one token with o_e=1 and o_d=0.
    - If not all 8 e flags matched, set err_eos_mix.
    - The row counter resets to 0 and blk_done does not pulse.
- Row counter (3-bit): increments per drained data row. When it wraps from 7 to 0, blk_done=1 for the cycle after the last word transfer.
- The scatter and gather sides run concurrently and independently. Back-to-back rows are allowed.

Decomposition:
- Shared package illm_seq_pkg holds:
  - LANES, IW, OW defaults.
  - Scatter state enum {SC_FILL, SC_ISSUE, SC_EOS}.
  - Gather state enum {GA_COLLECT, GA_DRAIN}.
- One natural sub-module, illm_row_gather: gather FSM, capture mask, serialiser and row counter. The scatter FSM stays in the top module.

Test Plan:
- Scatter basic: feed 8 tokens 0x0001..0x0008 with all la_b=0 -> la_v=8'hFF one cycle after the 8th accept; la_d lane i = i+1; s_b=1 for exactly one cycle.
- Staggered lanes: hold la_b[3]=1 for 5 cycles -> la_v[3] stays 1 with its data held, other lanes clear after 1 cycle; s_b deasserts only after lane 3 transfers.
- Gather order: present lb_v in order 7,0,5,… with data 9'h100+i and o_b toggling 1/0 -> o_d sequence 0x100..0x107 in lane order, no word lost or duplicated.
- Block boundary: 8 full rows -> blk_done pulses once, one cycle after the 64th output word.
- Partial EOS: 3 data tokens then s_e=1 -> err_partial=1; lane row [t0,t1,t2,0,0,0,0,0] issued, then all-lane EOS; downstream EOS rows -> single o_e=1 token.
- Reset mid-drain: assert reset after word 4 of a row -> next cycle o_v=0, lb_b=0, s_b=0; the next full row drains from word 0.
